// File: rtl/alu_stage_if.sv
// Issue bus from the reservation station and result bus onto the CDB for alu_stage.
// Holds the shared width and opcode defines when no project-wide header is present.
`ifndef ALU_STAGE_DEFS
`define ALU_STAGE_DEFS
`define INSIDE_OPCODE_WIDTH 6
`define DATA_WIDTH 32
`define ROB_TAG_WIDTH 4
`define ZERO_ROB_TAG 4'd0
`define NOP 6'd0
`define OP_ADD 6'd1
`define OP_SUB 6'd2
`define OP_AND 6'd3
`define OP_OR 6'd4
`define OP_XOR 6'd5
`define OP_SLL 6'd6
`define OP_SRL 6'd7
`define OP_SRA 6'd8
`define OP_SLT 6'd9
`define OP_SLTU 6'd10
`define OP_ADDI 6'd11
`define OP_ANDI 6'd12
`define OP_ORI 6'd13
`define OP_XORI 6'd14
`define OP_SLLI 6'd15
`define OP_SRLI 6'd16
`define OP_SRAI 6'd17
`define OP_SLTI 6'd18
`define OP_SLTIU 6'd19
`define OP_LUI 6'd20
`define OP_AUIPC 6'd21
`define OP_JAL 6'd22
`define OP_JALR 6'd23
`define OP_BEQ 6'd24
`define OP_BNE 6'd25
`define OP_BLT 6'd26
`define OP_BGE 6'd27
`define OP_BLTU 6'd28
`define OP_BGEU 6'd29
`endif

interface alu_stage_if;
    logic [`INSIDE_OPCODE_WIDTH-1:0] in_rs_op;
    logic [`DATA_WIDTH-1:0]          in_rs_value_rs1;
    logic [`DATA_WIDTH-1:0]          in_rs_value_rs2;
    logic [`DATA_WIDTH-1:0]          in_rs_imm;
    logic [`DATA_WIDTH-1:0]          in_rs_pc;
    logic [`ROB_TAG_WIDTH-1:0]       in_rs_reorder;
    logic                            in_misbranch;
    logic                            in_cdb_grant;
    logic [`ROB_TAG_WIDTH-1:0]       out_cdb_reorder;
    logic [`DATA_WIDTH-1:0]          out_cdb_value;
    logic                            out_cdb_jump;
    logic [`DATA_WIDTH-1:0]          out_cdb_target;
    logic                            out_fifo_almost_full;

    modport master (
        output in_rs_op, in_rs_value_rs1, in_rs_value_rs2, in_rs_imm, in_rs_pc,
               in_rs_reorder, in_misbranch, in_cdb_grant,
        input  out_cdb_reorder, out_cdb_value, out_cdb_jump, out_cdb_target,
               out_fifo_almost_full
    );

    modport slave (
        input  in_rs_op, in_rs_value_rs1, in_rs_value_rs2, in_rs_imm, in_rs_pc,
               in_rs_reorder, in_misbranch, in_cdb_grant,
        output out_cdb_reorder, out_cdb_value, out_cdb_jump, out_cdb_target,
               out_fifo_almost_full
    );
endinterface

// File: rtl/alu_stage.sv
// ALU/branch execute stage: computes results, queues them and broadcasts one per granted CDB cycle.
// Optional macro ALU_STAGE_BYPASS_EN: empty queue + grant sends the result straight to the CDB registers.
module alu_stage #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned FIFO_AW    = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    alu_stage_if.slave   bus
);
    localparam int unsigned DW = `DATA_WIDTH;
    localparam int unsigned TW = `ROB_TAG_WIDTH;
    localparam logic [FIFO_AW:0] FULL_CNT  = (FIFO_AW+1)'(FIFO_DEPTH);
    localparam logic [FIFO_AW:0] ALMOST_CNT = (FIFO_AW+1)'(FIFO_DEPTH - 1);

    typedef struct packed {
        logic [TW-1:0] reorder;
        logic [DW-1:0] value;
        logic          jump;
        logic [DW-1:0] target;
    } entry_t;

    entry_t               fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]   head, tail;
    logic [FIFO_AW:0]     count;
    entry_t               res, cdb_q;

    logic [DW-1:0] rs1, rs2, imm, pc, op2, br_target, jalr_sum;
    logic [4:0]    shamt;
    logic          accept, empty, full, pop, bypass, push, drop;

    assign rs1       = bus.in_rs_value_rs1;
    assign rs2       = bus.in_rs_value_rs2;
    assign imm       = bus.in_rs_imm;
    assign pc        = bus.in_rs_pc;
    assign shamt     = op2[4:0];
    assign br_target = pc + imm;
    assign jalr_sum  = rs1 + imm;

    always_comb begin
        op2 = rs2;
        case (bus.in_rs_op)
            `OP_ADDI, `OP_ANDI, `OP_ORI, `OP_XORI, `OP_SLLI,
            `OP_SRLI, `OP_SRAI, `OP_SLTI, `OP_SLTIU: op2 = imm;
            default: op2 = rs2;
        endcase
    end

    always_comb begin
        res.reorder = bus.in_rs_reorder;
        res.value   = '0;
        res.jump    = 1'b0;
        res.target  = '0;
        case (bus.in_rs_op)
            `OP_ADD,  `OP_ADDI:  res.value = rs1 + op2;
            `OP_SUB:             res.value = rs1 - op2;
            `OP_AND,  `OP_ANDI:  res.value = rs1 & op2;
            `OP_OR,   `OP_ORI:   res.value = rs1 | op2;
            `OP_XOR,  `OP_XORI:  res.value = rs1 ^ op2;
            `OP_SLL,  `OP_SLLI:  res.value = rs1 << shamt;
            `OP_SRL,  `OP_SRLI:  res.value = rs1 >> shamt;
            `OP_SRA,  `OP_SRAI:  res.value = $unsigned($signed(rs1) >>> shamt);
            `OP_SLT,  `OP_SLTI:  res.value = DW'($signed(rs1) < $signed(op2));
            `OP_SLTU, `OP_SLTIU: res.value = DW'(rs1 < op2);
            `OP_LUI:             res.value = imm;
            `OP_AUIPC:           res.value = br_target;
            `OP_JAL: begin
                res.value  = pc + DW'(4);
                res.target = br_target;
                res.jump   = 1'b1;
            end
            `OP_JALR: begin
                res.value  = pc + DW'(4);
                res.target = {jalr_sum[DW-1:1], 1'b0};
                res.jump   = 1'b1;
            end
            `OP_BEQ:  begin res.target = br_target; res.jump = (rs1 == rs2); end
            `OP_BNE:  begin res.target = br_target; res.jump = (rs1 != rs2); end
            `OP_BLT:  begin res.target = br_target; res.jump = ($signed(rs1) < $signed(rs2)); end
            `OP_BGE:  begin res.target = br_target; res.jump = ($signed(rs1) >= $signed(rs2)); end
            `OP_BLTU: begin res.target = br_target; res.jump = (rs1 < rs2); end
            `OP_BGEU: begin res.target = br_target; res.jump = (rs1 >= rs2); end
            default: ;
        endcase
    end

    assign accept = (bus.in_rs_op != `NOP) && (bus.in_rs_reorder != `ZERO_ROB_TAG);
    assign empty  = (count == '0);
    assign full   = (count == FULL_CNT);
    assign pop    = bus.in_cdb_grant && !empty;
`ifdef ALU_STAGE_BYPASS_EN
    assign bypass = bus.in_cdb_grant && empty && accept;
`else
    assign bypass = 1'b0;
`endif
    // A pop in the same cycle frees a slot, so a full queue can still take a push.
    assign push   = accept && !bypass && (!full || pop);
    assign drop   = accept && !bypass && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            cdb_q <= '0;
        end else if (rdy) begin
            cdb_q.reorder <= `ZERO_ROB_TAG;
            if (bus.in_misbranch) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (pop) begin
                    cdb_q <= fifo_mem[head];
                    head  <= head + 1'b1;
                end else if (bypass) begin
                    cdb_q <= res;
                end
                if (push) begin
                    fifo_mem[tail] <= res;
                    tail           <= tail + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
`ifndef SYNTHESIS
                if (drop)
                    $display("alu_stage: error, result queue full, issue dropped (tag %0d)",
                             bus.in_rs_reorder);
`endif
            end
        end
    end

    assign bus.out_cdb_reorder      = cdb_q.reorder;
    assign bus.out_cdb_value        = cdb_q.value;
    assign bus.out_cdb_jump         = cdb_q.jump;
    assign bus.out_cdb_target       = cdb_q.target;
    assign bus.out_fifo_almost_full = (count >= ALMOST_CNT);
endmodule

// File: tb/tb_alu_stage.sv
// Directed self-checking bench for alu_stage; expected latency follows ALU_STAGE_BYPASS_EN.
`ifndef ALU_STAGE_DEFS
`define ALU_STAGE_DEFS
`define INSIDE_OPCODE_WIDTH 6
`define DATA_WIDTH 32
`define ROB_TAG_WIDTH 4
`define ZERO_ROB_TAG 4'd0
`define NOP 6'd0
`define OP_ADD 6'd1
`define OP_SUB 6'd2
`define OP_AND 6'd3
`define OP_OR 6'd4
`define OP_XOR 6'd5
`define OP_SLL 6'd6
`define OP_SRL 6'd7
`define OP_SRA 6'd8
`define OP_SLT 6'd9
`define OP_SLTU 6'd10
`define OP_ADDI 6'd11
`define OP_ANDI 6'd12
`define OP_ORI 6'd13
`define OP_XORI 6'd14
`define OP_SLLI 6'd15
`define OP_SRLI 6'd16
`define OP_SRAI 6'd17
`define OP_SLTI 6'd18
`define OP_SLTIU 6'd19
`define OP_LUI 6'd20
`define OP_AUIPC 6'd21
`define OP_JAL 6'd22
`define OP_JALR 6'd23
`define OP_BEQ 6'd24
`define OP_BNE 6'd25
`define OP_BLT 6'd26
`define OP_BGE 6'd27
`define OP_BLTU 6'd28
`define OP_BGEU 6'd29
`endif

module tb_alu_stage;
    logic clk = 1'b0;
    logic rst;
    logic rdy;
    int   total = 0;
    int   bad   = 0;

    alu_stage_if bus ();

    alu_stage #(.FIFO_DEPTH(4), .FIFO_AW(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic [31:0] p, input logic [3:0] tag);
        bus.in_rs_op        = op;
        bus.in_rs_value_rs1 = a;
        bus.in_rs_value_rs2 = b;
        bus.in_rs_imm       = im;
        bus.in_rs_pc        = p;
        bus.in_rs_reorder   = tag;
    endtask

    task automatic idle();
        issue(`NOP, '0, '0, '0, '0, `ZERO_ROB_TAG);
    endtask

    // Issue one op with grant held and check the broadcast after the build's latency.
    task automatic run_op(input string name, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] im, input logic [31:0] p,
                          input logic [3:0] tag, input logic [31:0] ev, input logic ej,
                          input logic [31:0] et, input logic chk_t);
        bus.in_cdb_grant = 1'b1;
        issue(op, a, b, im, p, tag);
        step();
        idle();
`ifndef ALU_STAGE_BYPASS_EN
        check({name, ".early"}, 32'(bus.out_cdb_reorder), 32'd0);
        step();
`endif
        check({name, ".tag"},   32'(bus.out_cdb_reorder), 32'(tag));
        check({name, ".value"}, bus.out_cdb_value, ev);
        check({name, ".jump"},  32'(bus.out_cdb_jump), 32'(ej));
        if (chk_t)
            check({name, ".target"}, bus.out_cdb_target, et);
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        bus.in_misbranch = 1'b0;
        bus.in_cdb_grant = 1'b0;
        idle();
        step();
        step();
        check("rst.reorder", 32'(bus.out_cdb_reorder), 32'd0);
        check("rst.value",   bus.out_cdb_value, 32'd0);
        check("rst.jump",    32'(bus.out_cdb_jump), 32'd0);
        check("rst.target",  bus.out_cdb_target, 32'd0);
        check("rst.af",      32'(bus.out_fifo_almost_full), 32'd0);
        rst = 1'b0;
        step();

        // name op rs1 rs2 imm pc tag value jump target chk_target
        run_op("add",   `OP_ADD,   32'd5,        32'd7,  32'd0,        32'h0,    4'd3, 32'd12,       1'b0, 32'h0,   1'b0);
        step();
        check("add.once", 32'(bus.out_cdb_reorder), 32'd0);
        run_op("blt",   `OP_BLT,   32'hFFFFFFFF, 32'd1,  32'h20,       32'h100,  4'd4, 32'd0,        1'b1, 32'h120, 1'b1);
        run_op("bltu",  `OP_BLTU,  32'hFFFFFFFF, 32'd1,  32'h20,       32'h100,  4'd5, 32'd0,        1'b0, 32'h120, 1'b1);
        run_op("jalr",  `OP_JALR,  32'h1003,     32'd0,  32'd4,        32'h40,   4'd6, 32'h44,       1'b1, 32'h1006,1'b1);
        run_op("sub",   `OP_SUB,   32'd3,        32'd5,  32'd0,        32'h0,    4'd7, 32'hFFFFFFFE, 1'b0, 32'h0,   1'b0);
        run_op("sra",   `OP_SRA,   32'h80000000, 32'h24, 32'd0,        32'h0,    4'd8, 32'hF8000000, 1'b0, 32'h0,   1'b0);
        run_op("slli",  `OP_SLLI,  32'd1,        32'd0,  32'h1F,       32'h0,    4'd9, 32'h80000000, 1'b0, 32'h0,   1'b0);
        run_op("sltu",  `OP_SLTU,  32'd1,  32'hFFFFFFFF, 32'd0,        32'h0,    4'd10,32'd1,        1'b0, 32'h0,   1'b0);
        run_op("slt",   `OP_SLT,   32'd1,  32'hFFFFFFFF, 32'd0,        32'h0,    4'd11,32'd0,        1'b0, 32'h0,   1'b0);
        run_op("lui",   `OP_LUI,   32'd0,        32'd0,  32'h12345000, 32'h0,    4'd12,32'h12345000, 1'b0, 32'h0,   1'b0);
        run_op("auipc", `OP_AUIPC, 32'd0,        32'd0,  32'hFFFFF000, 32'h1000, 4'd13,32'h0,        1'b0, 32'h0,   1'b0);
        run_op("jal",   `OP_JAL,   32'd0,        32'd0,  32'hFFFFFFF0, 32'h200,  4'd14,32'h204,      1'b1, 32'h1F0, 1'b1);
        run_op("beq",   `OP_BEQ,   32'd9,        32'd9,  32'd8,        32'h10,   4'd15,32'd0,        1'b1, 32'h18,  1'b1);
        run_op("bne",   `OP_BNE,   32'd9,        32'd9,  32'd8,        32'h10,   4'd1, 32'd0,        1'b0, 32'h18,  1'b1);
        run_op("bge",   `OP_BGE,   32'hFFFFFFFF, 32'd1,  32'd8,        32'h10,   4'd2, 32'd0,        1'b0, 32'h18,  1'b1);
        run_op("bgeu",  `OP_BGEU,  32'hFFFFFFFF, 32'd1,  32'd8,        32'h10,   4'd3, 32'd0,        1'b1, 32'h18,  1'b1);
        run_op("xori",  `OP_XORI,  32'hF0F0,     32'd0,  32'hFF,       32'h0,    4'd4, 32'hF00F,     1'b0, 32'h0,   1'b0);
        step();

        // Fill the queue with grant low, then drain with a concurrent push.
        bus.in_cdb_grant = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            issue(`OP_ADDI, 32'(i * 10), 32'd0, 32'd0, 32'h0, 4'(i));
            step();
            check($sformatf("fill%0d.quiet", i), 32'(bus.out_cdb_reorder), 32'd0);
            check($sformatf("fill%0d.af", i), 32'(bus.out_fifo_almost_full), (i >= 3) ? 32'd1 : 32'd0);
        end
        bus.in_cdb_grant = 1'b1;
        issue(`OP_ADDI, 32'd50, 32'd0, 32'd0, 32'h0, 4'd5);
        for (int i = 1; i <= 5; i++) begin
            step();
            idle();
            check($sformatf("drain%0d.tag", i), 32'(bus.out_cdb_reorder), 32'(i));
            check($sformatf("drain%0d.value", i), bus.out_cdb_value, 32'(i * 10));
        end
        check("drain.af", 32'(bus.out_fifo_almost_full), 32'd0);
        step();
        check("drain.idle", 32'(bus.out_cdb_reorder), 32'd0);

        // Flush with two queued and a concurrent issue and grant.
        bus.in_cdb_grant = 1'b0;
        issue(`OP_ADD, 32'd1, 32'd1, 32'd0, 32'h0, 4'd1); step();
        issue(`OP_ADD, 32'd2, 32'd2, 32'd0, 32'h0, 4'd2); step();
        bus.in_misbranch = 1'b1;
        bus.in_cdb_grant = 1'b1;
        issue(`OP_ADD, 32'd3, 32'd3, 32'd0, 32'h0, 4'd4);
        step();
        check("flush.now", 32'(bus.out_cdb_reorder), 32'd0);
        bus.in_misbranch = 1'b0;
        idle();
        step();
        check("flush.after1", 32'(bus.out_cdb_reorder), 32'd0);
        step();
        check("flush.after2", 32'(bus.out_cdb_reorder), 32'd0);
        check("flush.af", 32'(bus.out_fifo_almost_full), 32'd0);
        run_op("postflush", `OP_ADD, 32'd20, 32'd22, 32'd0, 32'h0, 4'd5, 32'd42, 1'b0, 32'h0, 1'b0);
        step();

        // Stall with rdy low while a broadcast is on the bus and one entry waits.
        bus.in_cdb_grant = 1'b0;
        issue(`OP_ADD, 32'd1, 32'd1, 32'd0, 32'h0, 4'd6); step();
        issue(`OP_ADD, 32'd2, 32'd2, 32'd0, 32'h0, 4'd7); step();
        idle();
        bus.in_cdb_grant = 1'b1;
        step();
        check("rdy.first", 32'(bus.out_cdb_reorder), 32'd6);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rdy.hold%0d.tag", i), 32'(bus.out_cdb_reorder), 32'd6);
            check($sformatf("rdy.hold%0d.value", i), bus.out_cdb_value, 32'd2);
        end
        rdy = 1'b1;
        step();
        check("rdy.resume.tag", 32'(bus.out_cdb_reorder), 32'd7);
        check("rdy.resume.value", bus.out_cdb_value, 32'd4);
        step();
        check("rdy.once", 32'(bus.out_cdb_reorder), 32'd0);

        // Reset with entries pending discards them.
        bus.in_cdb_grant = 1'b0;
        issue(`OP_ADD, 32'd1, 32'd1, 32'd0, 32'h0, 4'd8); step();
        issue(`OP_ADD, 32'd2, 32'd2, 32'd0, 32'h0, 4'd9); step();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.in_cdb_grant = 1'b1;
        step();
        check("midrst.1", 32'(bus.out_cdb_reorder), 32'd0);
        step();
        check("midrst.2", 32'(bus.out_cdb_reorder), 32'd0);
        check("midrst.af", 32'(bus.out_fifo_almost_full), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
